// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache read/write port between fetch (r0) and load/store (r1).
// Grant->ack: EN_CYCLES+RD_LAT+1 cycles for reads, EN_CYCLES+1 for writes; losers simply stay pending.
module cache_port_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int EN_CYCLES = 2,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] c_read_addr,
  output logic [ADDR_W-1:0] c_write_addr,
  output logic [DATA_W-1:0] c_write_data,
  output logic              c_read_enable,
  output logic              c_write_enable,
  input  logic [DATA_W-1:0] c_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Phase counter counts down to zero; each state loads (duration - 1) on entry.
  localparam logic [3:0] EN_LOAD   = 4'(EN_CYCLES - 1);
  localparam logic [3:0] WAIT_LOAD = 4'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
  localparam bit         SKIP_WAIT = (RD_LAT == 0);

  state_t            state;
  logic [3:0]        phase;
  logic              last_grant;
  logic              cur_id;
  logic              cur_we;
  logic              pick;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              enter_done;

  // r1 wins when it is alone, or on a tie when r0 held the last grant.
  always_comb begin
    pick       = r1_req && (!r0_req || !last_grant);
    pick_we    = pick ? r1_we    : r0_we;
    pick_addr  = pick ? r1_addr  : r0_addr;
    pick_wdata = pick ? r1_wdata : r0_wdata;
  end

  assign enter_done = (phase == 4'd0) &&
                      ((state == WAIT) || ((state == ISSUE) && (cur_we || SKIP_WAIT)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      phase          <= '0;
      last_grant     <= 1'b1;
      cur_id         <= 1'b0;
      cur_we         <= 1'b0;
      busy           <= 1'b0;
      c_read_enable  <= 1'b0;
      c_write_enable <= 1'b0;
      c_read_addr    <= '0;
      c_write_addr   <= '0;
      c_write_data   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            state      <= ISSUE;
            phase      <= EN_LOAD;
            busy       <= 1'b1;
            last_grant <= pick;
            cur_id     <= pick;
            cur_we     <= pick_we;
            if (pick_we) begin
              c_write_enable <= 1'b1;
              c_write_addr   <= pick_addr;
              c_write_data   <= pick_wdata;
            end else begin
              c_read_enable <= 1'b1;
              c_read_addr   <= pick_addr;
            end
          end
        end
        ISSUE: begin
          if (phase == 4'd0) begin
            c_read_enable  <= 1'b0;
            c_write_enable <= 1'b0;
            if (enter_done) begin
              state <= DONE;
              phase <= '0;
            end else begin
              state <= WAIT;
              phase <= WAIT_LOAD;
            end
          end else begin
            phase <= phase - 4'd1;
          end
        end
        WAIT: begin
          if (phase == 4'd0) begin
            state <= DONE;
            phase <= '0;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          phase <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Acks and read data are registered on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_ack <= enter_done && !cur_id;
      r1_ack <= enter_done &&  cur_id;
      if (enter_done && !cur_we) begin
        if (cur_id) r1_rdata <= c_read_data;
        else        r0_rdata <= c_read_data;
      end
    end
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares the single read/write port of the cache between two requesters (r0 = instruction fetch, r1 = data load/store).
- Grants requesters round-robin and drives the cache's read_enable/write_enable pulses for a fixed number of cycles.
- Waits the cache's fixed read latency, then captures read_data and returns it with a one-cycle acknowledge.
- Sits directly in front of the cache; requesters never drive the cache directly.

Parameters:
- ADDR_W, 17, cache address width (3 tag, 10 index, 4 offset).
- DATA_W, 32, data word width.
- EN_CYCLES, 2, cycles the cache enable is held high per access (legal range 1..15).
- RD_LAT, 2, cycles after the enable drops before read_data is valid (legal range 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- r0_req  in  1  r0 access request; held with operands until r0_ack.
- r0_we  in  1  r0 write (1) / read (0).
- r0_addr  in  ADDR_W  r0 address.
- r0_wdata  in  DATA_W  r0 write data.
- r0_ack  out  1  one-cycle completion pulse for r0.
- r0_rdata  out  DATA_W  r0 read data; valid when r0_ack=1, held until next r0 read ack.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as r0, for r1.
- busy  out  1  high whenever the FSM is not IDLE.
- c_read_addr  out  ADDR_W  cache read address.
- c_write_addr  out  ADDR_W  cache write address.
- c_write_data  out  DATA_W  cache write data.
- c_read_enable  out  1  cache read strobe.
- c_write_enable  out  1  cache write strobe.
- c_read_data  in  DATA_W  cache read data.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE; last-grant pointer = r1, so r0 wins the first tie.
  - All outputs go to 0 at that edge, including c_*_enable, acks, rdata, cache address/data and busy.
- Reset asserted mid-operation aborts the access: no ack is issued, and enables drop at that same edge.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, select the winner and latch its id, we, addr and wdata; next state is ISSUE.
  - Arbitration: a single req wins outright. With both high, the requester not in the last-grant pointer wins. The pointer updates to the winner at grant.
- ISSUE, for EN_CYCLES cycles:
  - Read: c_read_enable=1 and c_read_addr = latched address.
  - Write: c_write_enable=1, with c_write_addr and c_write_data latched.
  - Only one enable is ever high; both are never high together.
  - Next state: reads go to WAIT (or to DONE if RD_LAT=0); writes go to DONE.
- WAIT, for RD_LAT cycles: enables are 0 and the cache address is held stable.
- DONE, one cycle:
  - The winner's ack=1.
  - For reads, the winner's rdata <= c_read_data, sampled at the edge entering DONE.
  - Next state is always IDLE.
- Latency, counting the cycle where IDLE samples req as cycle 0:
  - Read: enable high in cycles 1..EN_CYCLES; ack in cycle EN_CYCLES+RD_LAT+1. Defaults: enable in cycles 1–2, ack in cycle 5.
  - Write: ack in cycle EN_CYCLES+1 (cycle 3 by default).
  - Back-to-back accesses take a minimum of one IDLE cycle between grants.
- Requester rules:
  - Operands are captured at grant, so changes after grant are ignored.
  - Dropping req after grant does not cancel the access; ack is still pulsed.
  - A requester must deassert req in the cycle after its ack unless it has a new access.
- Fairness: with both reqs held continuously, grants alternate r0, r1, r0, ... No starvation.
- The loser's req stays pending untouched; no ack is issued to it.
- Counter: one 4-bit phase counter, reloaded on every state entry. No wrap is possible within the legal parameter ranges.

Test Plan:
1. Reset, then r0 reads 0x1380B (cache preloaded with 0xDEADBEEF there) -> c_read_enable high in cycles 1–2 only, c_read_addr=0x1380B, r0_ack in cycle 5, r0_rdata=0xDEADBEEF, r1_ack stays 0.
2. r1 writes 0x0F0F0F0F to 0x1380B, then r1 reads 0x1380B -> write ack in cycle 3, c_write_enable high for 2 cycles only, read returns 0x0F0F0F0F.
3. r0 and r1 both hold read requests (0x1380B and 0x1B80B) continuously for 4 accesses -> grant order r0, r1, r0, r1; each ack carries its own address's data; busy low exactly one cycle between accesses.
4. r0 drops req and changes r0_addr to 0x00000 one cycle after grant -> access to 0x1380B completes and r0_ack still pulses in cycle 5.
5. rst_n low during cycle 2 of ISSUE -> c_read_enable=0, busy=0 and both acks 0 at the next edge; no ack issued; the first tie after reset goes to r0.
6. Parameter override EN_CYCLES=1, RD_LAT=0 -> read ack in cycle 2 with correct data; write ack in cycle 2.
